// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between the truth-table sweeper and the
// function block / controller it serves.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic                   dut_out;
  logic [N_IN-1:0]        dut_in;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          fail_count;
  logic [N_IN-1:0]        first_fail_idx;
  logic [(1<<N_IN)-1:0]   captured;

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, fail_count, first_fail_idx, captured
  );

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, fail_count, first_fail_idx, captured
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper: drives every input vector, waits SETTLE_CYC, checks F.
// Optional macro STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module truth_table_sweeper #(
  parameter int                   N_IN       = 3,
  parameter int                   SETTLE_CYC = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED   = 8'b1110_1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);

  // state   | meaning
  // IDLE    | waiting for start, dut_in parked at 0
  // SETTLE  | holding dut_in while the function block settles
  // SAMPLE  | capture F and compare against EXPECTED
  // DONE    | one-cycle done pulse, result published
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int              NVEC     = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NVEC - 1);
  localparam logic [3:0]      CNT_LOAD = 4'(SETTLE_CYC - 1);

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [N_IN-1:0] r_idx;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_fail_count;
  logic [N_IN-1:0] r_first_fail;
  logic [NVEC-1:0] r_captured;

  logic            w_exp_bit;
  logic            w_mismatch;
  logic            w_last;
  logic            w_end;
  logic [N_IN:0]   w_fail_next;

  assign w_exp_bit   = EXPECTED[r_idx];
  assign w_mismatch  = bus.dut_out != w_exp_bit;
  assign w_last      = r_idx == LAST_IDX;
  assign w_fail_next = r_fail_count + (N_IN+1)'(w_mismatch);

`ifdef STOP_ON_FAIL_EN
  assign w_end = w_last | w_mismatch;
`else
  assign w_end = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_captured   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx  <= '0;
          r_busy <= 1'b0;
          if (bus.start) begin
            r_cnt        <= CNT_LOAD;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_captured   <= '0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) r_state <= S_SAMPLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_SAMPLE: begin
          r_captured[r_idx] <= bus.dut_out;
          r_fail_count      <= w_fail_next;
          if (w_mismatch && (r_fail_count == '0)) r_first_fail <= r_idx;
          if (w_end) begin
            // pass is published together with done, from the final count
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (w_fail_next == '0);
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_in         = r_idx;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.fail_count     = r_fail_count;
  assign bus.first_fail_idx = r_first_fail;
  assign bus.captured       = r_captured;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: default 3-input majority sweeper plus a 2-input XOR sweeper.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   mode;
  int   n_chk;
  int   n_bad;

  truth_table_sweeper_if #(.N_IN(3)) u_if ();
  truth_table_sweeper_if #(.N_IN(2)) u_if2 ();

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(2), .EXPECTED(8'b1110_1000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYC(1), .EXPECTED(4'b0110)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: correct majority, 1: stuck at 0, 2: majority inverted at vector 5
  function automatic logic model(input logic [2:0] v, input int m);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      1:       return 1'b0;
      2:       return (v == 3'd5) ? ~maj : maj;
      default: return maj;
    endcase
  endfunction

  assign u_if.dut_out  = model(u_if.dut_in, mode);
  assign u_if2.dut_out = ^u_if2.dut_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One sweep on the 3-input instance; nominal timing is 3 edges per vector.
  task automatic run_sweep(input bit repulse, output int lat, output int ndone,
                           output int seq_err);
    int exp_in;
    int exp_busy;
    lat = -1; ndone = 0; seq_err = 0;
    @(negedge clk) u_if.start = 1'b1;
    @(posedge clk); #1 u_if.start = 1'b0;
    if (u_if.dut_in !== 3'd0 || u_if.busy !== 1'b1) seq_err++;
    for (int n = 1; n <= 40; n++) begin
      if (repulse && (n == 5 || n == 10)) u_if.start = 1'b1;
      @(posedge clk); #1 u_if.start = 1'b0;
      if (n < 24)       begin exp_in = n / 3; exp_busy = 1; end
      else if (n == 24) begin exp_in = 7;     exp_busy = 0; end
      else              begin exp_in = 0;     exp_busy = 0; end
      if (u_if.dut_in !== 3'(exp_in) || u_if.busy !== 1'(exp_busy)) seq_err++;
      if (u_if.done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int seq_err;
    n_chk = 0; n_bad = 0; mode = 0;
    u_if.start = 1'b0; u_if2.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dut_in",   32'(u_if.dut_in), 32'd0);
    chk("rst_status",   {29'd0, u_if.busy, u_if.done, u_if.pass}, 32'd0);
    chk("rst_results",  32'({u_if.fail_count, u_if.first_fail_idx, u_if.captured}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // correct majority model
    run_sweep(1'b0, lat, ndone, seq_err);
    chk("maj_latency",  32'(lat), 32'd24);
    chk("maj_ndone",    32'(ndone), 32'd1);
    chk("maj_seq",      32'(seq_err), 32'd0);
    chk("maj_pass",     32'(u_if.pass), 32'd1);
    chk("maj_fcount",   32'(u_if.fail_count), 32'd0);
    chk("maj_captured", 32'(u_if.captured), 32'hE8);

    // stuck-at-0 model
    mode = 1;
    run_sweep(1'b0, lat, ndone, seq_err);
    chk("s0_latency",   32'(lat), 32'd24);
    chk("s0_fcount",    32'(u_if.fail_count), 32'd4);
    chk("s0_first",     32'(u_if.first_fail_idx), 32'd3);
    chk("s0_captured",  32'(u_if.captured), 32'h00);
    chk("s0_pass",      32'(u_if.pass), 32'd0);

    // single inverted vector 5
    mode = 2;
    run_sweep(1'b0, lat, ndone, seq_err);
    chk("inv5_fcount",   32'(u_if.fail_count), 32'd1);
    chk("inv5_first",    32'(u_if.first_fail_idx), 32'd5);
    chk("inv5_captured", 32'(u_if.captured), 32'hC8);
    chk("inv5_pass",     32'(u_if.pass), 32'd0);

    // reset during vector 4 settle
    mode = 0;
    @(negedge clk) u_if.start = 1'b1;
    @(posedge clk); #1 u_if.start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_rst_vec", 32'(u_if.dut_in), 32'd4);
    chk("pre_rst_cap", 32'(u_if.captured), 32'h08);
    rst_n = 1'b0;
    #1;
    chk("midrst_clear", 32'({u_if.busy, u_if.done, u_if.pass, u_if.fail_count,
                             u_if.first_fail_idx, u_if.captured, u_if.dut_in}), 32'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (u_if.done === 1'b1) ndone++;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if (u_if.done === 1'b1) ndone++;
    chk("midrst_nodone", 32'(ndone), 32'd0);
    run_sweep(1'b0, lat, ndone, seq_err);
    chk("postrst_latency", 32'(lat), 32'd24);
    chk("postrst_pass",    32'(u_if.pass), 32'd1);

    // start re-pulsed mid-sweep must be ignored
    run_sweep(1'b1, lat, ndone, seq_err);
    chk("repulse_latency", 32'(lat), 32'd24);
    chk("repulse_ndone",   32'(ndone), 32'd1);
    chk("repulse_seq",     32'(seq_err), 32'd0);
    chk("repulse_cap",     32'(u_if.captured), 32'hE8);

    // 2-input XOR instance, SETTLE_CYC=1
    lat = -1; ndone = 0; seq_err = 0;
    @(negedge clk) u_if2.start = 1'b1;
    @(posedge clk); #1 u_if2.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n < 8 && u_if2.dut_in !== 2'(n / 2)) seq_err++;
      if (u_if2.done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
    chk("xor_latency",  32'(lat), 32'd8);
    chk("xor_ndone",    32'(ndone), 32'd1);
    chk("xor_seq",      32'(seq_err), 32'd0);
    chk("xor_pass",     32'(u_if2.pass), 32'd1);
    chk("xor_captured", 32'(u_if2.captured), 32'h6);
    chk("xor_fcount",   32'(u_if2.fail_count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
